fpu_mem_requester: RTL and testbench

Memory-side responder for the FPU controller's request interface. It accepts one-cycle read/write request pulses with base addresses and a tile size. Read requests fill the inactive FPU read buffer from memory; write requests drain the result buffer to memory. `making_request` stays high until all transfers complete, and the controller stalls on it.

---
 rtl/fpu_mem_requester_pkg.sv | 21 ++
 rtl/fpu_mem_requester_if.sv | 24 ++
 rtl/fpu_xfer_counter.sv | 71 +++++++
 rtl/fpu_mem_requester.sv | 193 +++++++++++++++++++
 tb/tb_fpu_mem_requester.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_mem_requester_pkg.sv
// Shared types and helpers for the FPU memory requester.
// Holds the beat size, the transfer state encoding and line-count math.
package fpu_mem_pkg;

    localparam int LINE_BYTES = 64;
    localparam int LINE_SH    = $clog2(LINE_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        WR_FETCH,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT,
        FIN
    } req_state_e;

    function automatic logic [3:0] lines_for(input logic [9:0] w);
        return 4'((w + 10'(LINE_BYTES - 1)) >> LINE_SH);
    endfunction

endpackage

// File: rtl/fpu_mem_requester_if.sv
// Single-outstanding memory command bus between requester and memory.
// The master issues commands; the slave accepts and returns read data.
interface fpu_mem_requester_if;

    logic         req;
    logic         we;
    logic [31:0]  addr;
    logic [511:0] wdata;
    logic [63:0]  be;
    logic         ready;
    logic         rvalid;
    logic [511:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rvalid, rdata
    );

endinterface

// File: rtl/fpu_xfer_counter.sv
// Row/line walker for one transfer phase: beat address, indices,
// last-beat flag and byte enables for a partial final line.
module fpu_xfer_counter #(
    parameter int STEP  = 64,
    parameter int ROW_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             adv,
    input  logic [31:0]      base,
    input  logic [31:0]      stride,
    input  logic [17:0]      rows,
    input  logic [3:0]       lines,
    input  logic [5:0]       rem,
    output logic [ROW_W-1:0] row_idx,
    output logic [2:0]       line_idx,
    output logic [31:0]      addr,
    output logic             last_beat,
    output logic [63:0]      be
);
    import fpu_mem_pkg::*;

    logic [17:0] row_q;
    logic [17:0] rows_q;
    logic [2:0]  line_q;
    logic [3:0]  lines_q;
    logic [5:0]  rem_q;
    logic [31:0] base_q;
    logic [31:0] addr_q;
    logic        last_line;

    assign last_line = ({1'b0, line_q} == lines_q - 4'd1);
    assign last_beat = last_line && (row_q == rows_q - 18'd1);
    assign be        = (last_line && rem_q != '0) ?
                       (64'd1 << rem_q) - 64'd1 : '1;
    assign row_idx   = row_q[ROW_W-1:0];
    assign line_idx  = line_q;
    assign addr      = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            rows_q  <= '0;
            line_q  <= '0;
            lines_q <= '0;
            rem_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
        end else if (load) begin
            row_q   <= '0;
            rows_q  <= rows;
            line_q  <= '0;
            lines_q <= lines;
            rem_q   <= rem;
            base_q  <= base;
            addr_q  <= base;
        end else if (adv) begin
            if (last_line) begin
                row_q  <= row_q + 18'd1;
                line_q <= '0;
                base_q <= base_q + stride;
                addr_q <= base_q + stride;
            end else begin
                line_q <= line_q + 3'd1;
                addr_q <= addr_q + 32'(STEP);
            end
        end
    end

endmodule

// File: rtl/fpu_mem_requester.sv
// Memory-side responder: fills the FPU read buffer from memory and
// drains the result buffer back, one outstanding beat at a time.
module fpu_mem_requester #(
    parameter int  COL_WIDTH        = 10,
    parameter int  MEM_BUFFER_WIDTH = 512,
    parameter int  LINE_BYTES       = 64,
    localparam int ROW_W            = $clog2(COL_WIDTH + 2),
    localparam int LB_SH            = $clog2(LINE_BYTES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_read,
    input  logic                req_write,
    input  logic [31:0]         read_address,
    input  logic [31:0]         write_address,
    input  logic [18:0]         req_width,
    input  logic [16:0]         req_height,
    input  logic [31:0]         row_stride,
    output logic                making_request,
    output logic                req_done,
    fpu_mem_requester_if.master mem,
    output logic                rdbuf_we,
    output logic [ROW_W-1:0]    rdbuf_row,
    output logic [2:0]          rdbuf_line,
    output logic [511:0]        rdbuf_data,
    output logic                wrbuf_re,
    output logic [ROW_W-1:0]    wrbuf_row,
    output logic [2:0]          wrbuf_line,
    input  logic [511:0]        wrbuf_data
);
    import fpu_mem_pkg::*;

    req_state_e state_q;

    logic             pr_q;
    logic [31:0]      raddr_q;
    logic [9:0]       w_q;
    logic [16:0]      h_q;
    logic             req_q;
    logic             we_q;
    logic             wd_fresh;
    logic [511:0]     wdata_q;

    logic [9:0]       w_in;
    logic [9:0]       w_ld;
    logic             pulse;
    logic             do_w;
    logic             do_r;
    logic             accept;
    logic             last_beat;
    logic             ld;
    logic             adv;
    logic [31:0]      ld_base;
    logic [17:0]      ld_rows;
    logic [31:0]      cnt_addr;
    logic [63:0]      cnt_be;
    logic [ROW_W-1:0] cnt_row;
    logic [2:0]       cnt_line;

    assign w_in   = (req_width > 19'(MEM_BUFFER_WIDTH)) ?
                    10'(MEM_BUFFER_WIDTH) : req_width[9:0];
    assign pulse  = (state_q == IDLE) && (req_read || req_write);
    assign do_w   = req_write && (w_in != '0) && (req_height != '0);
    assign do_r   = req_read && (w_in != '0);
    assign accept = req_q && mem.ready;

    // Reload for the read phase on the final write accept.
    assign ld      = pulse ||
                     (state_q == WR_ISSUE && accept && last_beat && pr_q);
    assign ld_base = pulse ? (do_w ? write_address : read_address) : raddr_q;
    assign ld_rows = pulse ?
                     (do_w ? {1'b0, req_height} : {1'b0, req_height} + 18'd2) :
                     {1'b0, h_q} + 18'd2;
    assign w_ld    = pulse ? w_in : w_q;
    assign adv     = (state_q == WR_ISSUE && accept) ||
                     (state_q == RD_WAIT && mem.rvalid);

    assign making_request = (state_q != IDLE) || req_read || req_write;

    // Result data arrives the cycle after wrbuf_re; hold it from then on.
    assign mem.req   = req_q;
    assign mem.we    = we_q;
    assign mem.addr  = cnt_addr;
    assign mem.wdata = wd_fresh ? wrbuf_data : wdata_q;
    assign mem.be    = we_q ? cnt_be : '0;

    assign wrbuf_row  = cnt_row;
    assign wrbuf_line = cnt_line;

    fpu_xfer_counter #(
        .STEP  (LINE_BYTES),
        .ROW_W (ROW_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ld),
        .adv       (adv),
        .base      (ld_base),
        .stride    (row_stride),
        .rows      (ld_rows),
        .lines     (lines_for(w_ld)),
        .rem       (w_ld[LB_SH-1:0]),
        .row_idx   (cnt_row),
        .line_idx  (cnt_line),
        .addr      (cnt_addr),
        .last_beat (last_beat),
        .be        (cnt_be)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pr_q       <= 1'b0;
            raddr_q    <= '0;
            w_q        <= '0;
            h_q        <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            wd_fresh   <= 1'b0;
            wdata_q    <= '0;
            wrbuf_re   <= 1'b0;
            rdbuf_we   <= 1'b0;
            rdbuf_row  <= '0;
            rdbuf_line <= '0;
            rdbuf_data <= '0;
            req_done   <= 1'b0;
        end else begin
            wrbuf_re <= 1'b0;
            rdbuf_we <= 1'b0;
            req_done <= 1'b0;
            wd_fresh <= 1'b0;
            if (wd_fresh) wdata_q <= wrbuf_data;
            unique case (state_q)
                IDLE: if (pulse) begin
                    pr_q    <= do_r;
                    raddr_q <= read_address;
                    w_q     <= w_in;
                    h_q     <= req_height;
                    if (do_w) begin
                        state_q  <= WR_FETCH;
                        wrbuf_re <= 1'b1;
                    end else if (do_r) begin
                        state_q <= RD_ISSUE;
                        req_q   <= 1'b1;
                    end else begin
                        state_q  <= FIN;
                        req_done <= 1'b1;
                    end
                end
                WR_FETCH: begin
                    state_q  <= WR_ISSUE;
                    req_q    <= 1'b1;
                    we_q     <= 1'b1;
                    wd_fresh <= 1'b1;
                end
                WR_ISSUE: if (mem.ready) begin
                    req_q <= 1'b0;
                    we_q  <= 1'b0;
                    if (!last_beat) begin
                        state_q  <= WR_FETCH;
                        wrbuf_re <= 1'b1;
                    end else if (pr_q) begin
                        state_q <= RD_ISSUE;
                        req_q   <= 1'b1;
                    end else begin
                        state_q  <= FIN;
                        req_done <= 1'b1;
                    end
                end
                RD_ISSUE: if (mem.ready) begin
                    req_q   <= 1'b0;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: if (mem.rvalid) begin
                    rdbuf_we   <= 1'b1;
                    rdbuf_data <= mem.rdata;
                    rdbuf_row  <= cnt_row;
                    rdbuf_line <= cnt_line;
                    if (last_beat) begin
                        state_q  <= FIN;
                        req_done <= 1'b1;
                    end else begin
                        state_q <= RD_ISSUE;
                        req_q   <= 1'b1;
                    end
                end
                FIN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mem_requester.sv
// Scoreboard bench: requests push expected memory/buffer events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_fpu_mem_requester;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_read = 1'b0;
    logic         req_write = 1'b0;
    logic [31:0]  read_address = '0;
    logic [31:0]  write_address = '0;
    logic [18:0]  req_width = '0;
    logic [16:0]  req_height = '0;
    logic [31:0]  row_stride = '0;
    logic         making_request;
    logic         req_done;
    logic         rdbuf_we;
    logic [3:0]   rdbuf_row;
    logic [2:0]   rdbuf_line;
    logic [511:0] rdbuf_data;
    logic         wrbuf_re;
    logic [3:0]   wrbuf_row;
    logic [2:0]   wrbuf_line;
    logic [511:0] wrbuf_data = '0;

    logic         ready_en = 1'b1;
    int           lat = 2;

    fpu_mem_requester_if mem_bus();

    always #5 clk = ~clk;

    fpu_mem_requester dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_read       (req_read),
        .req_write      (req_write),
        .read_address   (read_address),
        .write_address  (write_address),
        .req_width      (req_width),
        .req_height     (req_height),
        .row_stride     (row_stride),
        .making_request (making_request),
        .req_done       (req_done),
        .mem            (mem_bus),
        .rdbuf_we       (rdbuf_we),
        .rdbuf_row      (rdbuf_row),
        .rdbuf_line     (rdbuf_line),
        .rdbuf_data     (rdbuf_data),
        .wrbuf_re       (wrbuf_re),
        .wrbuf_row      (wrbuf_row),
        .wrbuf_line     (wrbuf_line),
        .wrbuf_data     (wrbuf_data)
    );

    function automatic logic [511:0] rd_pat(logic [31:0] a);
        return {16{a ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [511:0] wr_pat(logic [3:0] r, logic [2:0] l);
        return {16{32'hC0DE_0000 | {25'd0, r, l}}};
    endfunction

    // Memory and result-buffer models
    assign mem_bus.ready = ready_en;

    logic        pend;
    logic [31:0] pend_addr;
    int          lat_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend           <= 1'b0;
            pend_addr      <= '0;
            lat_cnt        <= 0;
            mem_bus.rvalid <= 1'b0;
            mem_bus.rdata  <= '0;
        end else begin
            mem_bus.rvalid <= 1'b0;
            if (pend) begin
                if (lat_cnt == 0) begin
                    mem_bus.rvalid <= 1'b1;
                    mem_bus.rdata  <= rd_pat(pend_addr);
                    pend           <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
            if (mem_bus.req && mem_bus.ready && !mem_bus.we) begin
                pend      <= 1'b1;
                pend_addr <= mem_bus.addr;
                lat_cnt   <= lat;
            end
        end
    end

    always @(posedge clk)
        if (wrbuf_re) wrbuf_data <= wr_pat(wrbuf_row, wrbuf_line);

    typedef enum int {EV_WR, EV_RD, EV_BUF, EV_DONE} ev_k;
    typedef struct {
        ev_k          k;
        logic [31:0]  addr;
        logic [511:0] data;
        logic [63:0]  be;
        logic [3:0]   row;
        logic [2:0]   line;
    } ev_t;

    ev_t         q[$];
    logic [31:0] rd_log[$];
    logic [63:0] wr_be_log[$];
    logic [3:0]  last_row;
    logic [2:0]  last_line;
    int          checks = 0;
    int          failures = 0;
    int          busy = 0;
    logic        req_prev = 1'b0;
    logic        re_prev = 1'b0;

    task automatic check(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic push(ev_k k, logic [31:0] a, logic [511:0] d,
                        logic [63:0] b, logic [3:0] r, logic [2:0] l);
        ev_t e;
        e.k = k; e.addr = a; e.data = d; e.be = b; e.row = r; e.line = l;
        q.push_back(e);
    endtask

    task automatic plan(bit rd, bit wr, logic [31:0] ra, logic [31:0] wa,
                        int w, int h, logic [31:0] st);
        int wc, lines, rem;
        logic [31:0] a;
        logic [63:0] b;
        wc    = (w > 512) ? 512 : w;
        lines = (wc + 63) / 64;
        rem   = wc % 64;
        if (wr && wc != 0 && h != 0)
            for (int r = 0; r < h; r++)
                for (int l = 0; l < lines; l++) begin
                    a = wa + 32'(r) * st + 32'(l * 64);
                    b = (l == lines - 1 && rem != 0) ?
                        (64'd1 << rem) - 64'd1 : '1;
                    push(EV_WR, a, wr_pat(4'(r), 3'(l)), b, 0, 0);
                end
        if (rd && wc != 0)
            for (int r = 0; r < h + 2; r++)
                for (int l = 0; l < lines; l++) begin
                    a = ra + 32'(r) * st + 32'(l * 64);
                    push(EV_RD, a, 0, 0, 0, 0);
                    push(EV_BUF, 0, rd_pat(a), 0, 4'(r), 3'(l));
                end
        push(EV_DONE, 0, 0, 0, 0, 0);
    endtask

    task automatic take(ev_k k, logic [31:0] a, logic [511:0] d,
                        logic [63:0] b, logic [3:0] r, logic [2:0] l);
        ev_t e;
        if (k == EV_RD) rd_log.push_back(a);
        if (k == EV_WR) wr_be_log.push_back(b);
        if (k == EV_BUF) begin last_row = r; last_line = l; end
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_%s act=event required=none", k.name());
            return;
        end
        e = q.pop_front();
        check("ev_kind", k, e.k);
        case (e.k)
            EV_WR: begin
                check("wr_addr", a, e.addr);
                check("wr_data", d, e.data);
                check("wr_be", b, e.be);
            end
            EV_RD: check("rd_addr", a, e.addr);
            EV_BUF: begin
                check("buf_row", r, e.row);
                check("buf_line", l, e.line);
                check("buf_data", d, e.data);
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            req_prev = 1'b0;
            re_prev  = 1'b0;
        end else begin
            if (rdbuf_we)
                take(EV_BUF, 0, rdbuf_data, 0, rdbuf_row, rdbuf_line);
            if (mem_bus.req && mem_bus.ready)
                take(mem_bus.we ? EV_WR : EV_RD, mem_bus.addr,
                     mem_bus.wdata, mem_bus.be, 0, 0);
            if (req_done)
                take(EV_DONE, 0, 0, 0, 0, 0);
            if (mem_bus.req && mem_bus.we && !req_prev)
                check("wrbuf_re_lead", re_prev, 1);
            req_prev = mem_bus.req;
            re_prev  = wrbuf_re;
        end
    end

    task automatic issue(bit rd, bit wr, logic [31:0] ra, logic [31:0] wa,
                         int w, int h, logic [31:0] st);
        plan(rd, wr, ra, wa, w, h, st);
        @(posedge clk); #1;
        req_read      = rd;
        req_write     = wr;
        read_address  = ra;
        write_address = wa;
        req_width     = 19'(w);
        req_height    = 17'(h);
        row_stride    = st;
        @(negedge clk);
        busy = making_request ? 1 : 0;
        @(posedge clk); #1;
        req_read  = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic wait_done(string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (making_request) busy++;
            else begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        check({name, "_idle"}, ok, 1);
        check({name, "_drain"}, q.size(), 0);
        q.delete();
    endtask

    task automatic chk_zero(string name);
        check({name, "_ctl"}, {mem_bus.req, mem_bus.we, wrbuf_re, rdbuf_we,
                               req_done, making_request}, 0);
        check({name, "_addr"}, mem_bus.addr, 0);
        check({name, "_wdata"}, mem_bus.wdata, 0);
        check({name, "_be"}, mem_bus.be, 0);
        check({name, "_rdata"}, rdbuf_data, 0);
        check({name, "_idx"}, {rdbuf_row, rdbuf_line, wrbuf_row, wrbuf_line}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  sa;
        logic [511:0] sd;
        logic [63:0]  sb;
        bit           seen;
        bit           stable;

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // Read only, full width, 10 rows x 8 beats
        rd_log.delete();
        issue(1, 0, 32'h1000_0200, 0, 512, 8, 32'd1536);
        wait_done("t1");
        check("t1_nbeats", rd_log.size(), 80);
        check("t1_row1_addr", rd_log[8], 32'h1000_0800);
        check("t1_last_row", last_row, 9);
        check("t1_last_line", last_line, 7);

        // Write only, partial last line
        wr_be_log.delete();
        issue(0, 1, 0, 32'h2000_0000, 100, 2, 32'h100);
        wait_done("t2");
        check("t2_busy", busy, 10);
        check("t2_nbeats", wr_be_log.size(), 4);
        check("t2_be_l0", wr_be_log[0], 64'hFFFF_FFFF_FFFF_FFFF);
        check("t2_be_l1", wr_be_log[1], 64'h0000_000F_FFFF_FFFF);

        // Simultaneous: 2 write beats then 6 read beats
        issue(1, 1, 32'h3000_0000, 32'h3800_0000, 128, 1, 32'h400);
        wait_done("t3");
        check("t3_busy", busy, 36);

        // Width clipped to a full buffer row
        wr_be_log.delete();
        issue(0, 1, 0, 32'h4000_0000, 700, 1, 0);
        wait_done("t4");
        check("t4_nbeats", wr_be_log.size(), 8);

        // Stall with mem_ready low
        ready_en = 1'b0;
        issue(0, 1, 0, 32'h4400_0040, 40, 1, 0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_bus.req) begin seen = 1'b1; break; end
        end
        check("t5_req_seen", seen, 1);
        sa = mem_bus.addr;
        sd = mem_bus.wdata;
        sb = mem_bus.be;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!mem_bus.req || mem_bus.addr !== sa ||
                mem_bus.wdata !== sd || mem_bus.be !== sb)
                stable = 1'b0;
        end
        check("t5_stable", stable, 1);
        check("t5_be", sb, 64'h0000_00FF_FFFF_FFFF);
        @(posedge clk); #1;
        ready_en = 1'b1;
        wait_done("t5");

        // Reset in the middle of a read
        issue(1, 0, 32'h5000_0000, 0, 512, 8, 32'h800);
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("t6_rst");
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd_log.delete();
        issue(1, 0, 32'h6000_0000, 0, 64, 1, 32'h200);
        wait_done("t6");
        check("t6_nbeats", rd_log.size(), 3);

        // Zero width: pulse + FIN only
        issue(1, 1, 32'h7000_0000, 32'h7800_0000, 0, 4, 32'h100);
        wait_done("t7");
        check("t7_busy", busy, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
